// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 UART receiver with an AXI-Stream master output.
//
// Recovers frames from the asynchronous rx_i line (LSB first, one stop bit)
// using the same prescale convention as uart_tx: bit period = prescale_i*8
// clock cycles (prescale_i == 0 behaves as 1).
//
// Ports:
//   clk_i            system clock, rising edge
//   rst_i            synchronous active-high reset
//   rx_i             serial line, idles high
//   prescale_i       baud setting, latched at each start detection
//   m_axis_tdata_o   received byte
//   m_axis_tvalid_o  byte available, held until tvalid && tready
//   m_axis_tready_i  consumer accepts the byte
//   busy_o           frame in progress (state != IDLE)
//   overrun_error_o  1-cycle pulse: new byte overwrote an unaccepted one
//   frame_error_o    1-cycle pulse: stop bit sampled low
//
// Build option: define UART_RX_MAJORITY_EN to take every start/data/stop
// decision as the 2-of-3 majority of the synchronized line around the
// nominal sample cycle. All decisions (and tvalid) then land one cycle later.

module uart_byte_rx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  rx_i,
    input  logic [15:0]           prescale_i,
    output logic [DATA_WIDTH-1:0] m_axis_tdata_o,
    output logic                  m_axis_tvalid_o,
    input  logic                  m_axis_tready_i,
    output logic                  busy_o,
    output logic                  overrun_error_o,
    output logic                  frame_error_o
);

    localparam int BW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t                state_q, state_d;
    logic                  rx_meta, rxs;
    logic                  sample;
    logic [18:0]           cnt_q, cnt_d;
    logic [18:0]           period_q, period_d;
    logic [18:0]           start_at;
    logic [BW-1:0]         bits_q, bits_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  load_byte, frame_err;
    logic [15:0]           psc;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rxs     <= rx_meta;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // Decision is made one cycle after the nominal sample so that rxs holds
    // the +1 sample while the two history flops hold 0 and -1.
    localparam logic [18:0] START_LAG = 19'd1;
    logic rxs_q, rxs_qq;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rxs_q  <= 1'b1;
            rxs_qq <= 1'b1;
        end else begin
            rxs_q  <= rxs;
            rxs_qq <= rxs_q;
        end
    end

    assign sample = (rxs & rxs_q) | (rxs & rxs_qq) | (rxs_q & rxs_qq);
`else
    localparam logic [18:0] START_LAG = 19'd0;
    assign sample = rxs;
`endif

    assign psc      = (prescale_i == 16'd0) ? 16'd1 : prescale_i;
    // Only the start delay carries the lag; data/stop spacing stays P, so
    // every later decision inherits the same one-cycle shift.
    assign start_at = {1'b0, period_q[18:1]} - 19'd1 + START_LAG;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            period_q <= 19'd8;
            bits_q   <= '0;
            shreg_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            bits_q   <= bits_d;
            shreg_q  <= shreg_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 19'd1;
        period_d  = period_q;
        bits_d    = bits_q;
        shreg_d   = shreg_q;
        load_byte = 1'b0;
        frame_err = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rxs) begin
                    period_d = {psc, 3'b000};
                    state_d  = S_START;
                end
            end
            S_START: begin
                if (cnt_q == start_at) begin
                    cnt_d   = '0;
                    bits_d  = '0;
                    state_d = sample ? S_IDLE : S_DATA;  // high here = glitch
                end
            end
            S_DATA: begin
                if (cnt_q == period_q - 19'd1) begin
                    cnt_d   = '0;
                    shreg_d = {sample, shreg_q[DATA_WIDTH-1:1]};
                    bits_d  = bits_q + 1'b1;
                    if (bits_q == BW'(DATA_WIDTH - 1))
                        state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt_q == period_q - 19'd1) begin
                    cnt_d = '0;
                    if (sample) begin
                        load_byte = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        frame_err = 1'b1;
                        state_d   = S_WAIT_HIGH;
                    end
                end
            end
            S_WAIT_HIGH: begin
                // Hold off until the line recovers so a break is not
                // decoded as a train of start bits.
                cnt_d = '0;
                if (rxs)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output register: a new byte load wins over a same-cycle handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            m_axis_tdata_o  <= '0;
            m_axis_tvalid_o <= 1'b0;
            overrun_error_o <= 1'b0;
            frame_error_o   <= 1'b0;
        end else begin
            overrun_error_o <= load_byte && m_axis_tvalid_o && !m_axis_tready_i;
            frame_error_o   <= frame_err;
            if (load_byte) begin
                m_axis_tdata_o  <= shreg_q;
                m_axis_tvalid_o <= 1'b1;
            end else if (m_axis_tvalid_o && m_axis_tready_i) begin
                m_axis_tvalid_o <= 1'b0;
            end
        end
    end

    assign busy_o = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed bench for uart_byte_rx: basic byte with latency, backpressure and
// overrun, false start, framing error with break, reset mid-frame, prescale 0,
// and the mid-bit glitch pattern that separates the majority build.

module tb_uart_byte_rx;

`ifdef UART_RX_MAJORITY_EN
    localparam int LAG = 1;
`else
    localparam int LAG = 0;
`endif
    localparam int P = 72;
    localparam int H = 36;

    logic        clk;
    logic        rst;
    logic        rx;
    logic [15:0] prescale;
    logic [7:0]  tdata;
    logic        tvalid;
    logic        tready;
    logic        busy;
    logic        ovr;
    logic        ferr;

    uart_byte_rx #(.DATA_WIDTH(8)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .rx_i            (rx),
        .prescale_i      (prescale),
        .m_axis_tdata_o  (tdata),
        .m_axis_tvalid_o (tvalid),
        .m_axis_tready_i (tready),
        .busy_o          (busy),
        .overrun_error_o (ovr),
        .frame_error_o   (ferr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor: cumulative counts only; the main flow takes snapshots.
    int   rise_cnt = 0, rise_cyc = 0, thi_cnt = 0;
    int   ovr_cnt = 0, ferr_cnt = 0, busy_cnt = 0;
    logic [7:0] rise_data = 8'h00;
    logic tv_prev = 1'b0;
    always @(negedge clk) begin
        if (tvalid && !tv_prev) begin
            rise_cnt  = rise_cnt + 1;
            rise_cyc  = cyc;
            rise_data = tdata;
        end
        tv_prev = tvalid;
        if (tvalid) thi_cnt  = thi_cnt + 1;
        if (ovr)    ovr_cnt  = ovr_cnt + 1;
        if (ferr)   ferr_cnt = ferr_cnt + 1;
        if (busy)   busy_cnt = busy_cnt + 1;
    end

    int s_rise, s_thi, s_ovr, s_ferr, s_busy;
    task automatic snap();
        s_rise = rise_cnt; s_thi = thi_cnt; s_ovr = ovr_cnt;
        s_ferr = ferr_cnt; s_busy = busy_cnt;
    endtask

    int n_chk = 0, n_pass = 0;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (obs === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // All line drives happen 1 time unit after a rising edge.
    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_ok, input int p);
        rx = 1'b0;
        hold(p);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            hold(p);
        end
        rx = stop_ok;
        hold(p);
    endtask

    int t0;

    initial begin
        rst = 1'b1; rx = 1'b1; tready = 1'b1; prescale = 16'd9;
        hold(3);
        @(negedge clk);
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tdata",  tdata,  0);
        chk("rst_busy",   busy,   0);
        chk("rst_ovr",    ovr,    0);
        chk("rst_ferr",   ferr,   0);
        hold(1);
        rst = 1'b0;
        hold(10);

        // Basic byte and exact latency from the start edge
        snap();
        t0 = cyc;
        send_frame(8'h55, 1'b1, P);
        hold(10);
        chk("basic_rises",   rise_cnt - s_rise, 1);
        chk("basic_data",    rise_data, 8'h55);
        chk("basic_latency", rise_cyc - t0, 2 + H + 9*P + 1 + LAG);
        chk("basic_vld_len", thi_cnt - s_thi, 1);
        chk("basic_ovr",     ovr_cnt - s_ovr, 0);
        chk("basic_ferr",    ferr_cnt - s_ferr, 0);

        // Backpressure: two back-to-back frames with tready low
        tready = 1'b0;
        snap();
        send_frame(8'hA3, 1'b1, P);
        send_frame(8'h3C, 1'b1, P);
        hold(5);
        @(negedge clk);
        chk("bp_rises",    rise_cnt - s_rise, 1);
        chk("bp_first",    rise_data, 8'hA3);
        chk("bp_ovr",      ovr_cnt - s_ovr, 1);
        chk("bp_tdata",    tdata, 8'h3C);
        chk("bp_tvalid",   tvalid, 1);
        hold(1);
        tready = 1'b1;
        @(negedge clk);
        chk("bp_hold_til_edge", tvalid, 1);
        @(negedge clk);
        chk("bp_cleared",  tvalid, 0);
        hold(10);

        // False start: 20-cycle low glitch
        snap();
        rx = 1'b0;
        hold(20);
        rx = 1'b1;
        hold(100);
        chk("fs_busy_len", busy_cnt - s_busy, H + LAG);
        chk("fs_rises",    rise_cnt - s_rise, 0);
        chk("fs_ferr",     ferr_cnt - s_ferr, 0);
        chk("fs_ovr",      ovr_cnt - s_ovr, 0);

        // Framing error followed by a break of 3P, then a good byte
        snap();
        send_frame(8'hFF, 1'b0, P);
        hold(3*P);
        rx = 1'b1;
        hold(2*P);
        chk("fe_pulse",    ferr_cnt - s_ferr, 1);
        chk("fe_no_vld",   rise_cnt - s_rise, 0);
        send_frame(8'h12, 1'b1, P);
        hold(10);
        chk("fe_next_rise", rise_cnt - s_rise, 1);
        chk("fe_next_data", rise_data, 8'h12);
        chk("fe_single",    ferr_cnt - s_ferr, 1);

        // Reset during data bit 4 of 8'hC7
        snap();
        rx = 1'b0;
        hold(P);
        for (int i = 0; i < 4; i++) begin
            rx = (8'hC7 >> i) & 8'h01;
            hold(P);
        end
        rx = 1'b0;            // bit 4 of C7
        hold(20);
        @(negedge clk);
        chk("mr_busy_pre", busy, 1);
        hold(0);
        @(posedge clk); #1;
        rst = 1'b1;
        rx  = 1'b1;
        hold(1);
        rst = 1'b0;
        @(negedge clk);
        chk("mr_tvalid", tvalid, 0);
        chk("mr_tdata",  tdata,  0);
        chk("mr_busy",   busy,   0);
        chk("mr_flags",  {30'd0, ovr, ferr}, 0);
        hold(20);
        send_frame(8'h81, 1'b1, P);
        hold(10);
        chk("mr_next_rise", rise_cnt - s_rise, 1);
        chk("mr_next_data", rise_data, 8'h81);
        chk("mr_no_ferr",   ferr_cnt - s_ferr, 0);

        // prescale 0 behaves as 1 (P = 8)
        prescale = 16'd0;
        snap();
        send_frame(8'hA5, 1'b1, 8);
        hold(10);
        chk("ps0_rise", rise_cnt - s_rise, 1);
        chk("ps0_data", rise_data, 8'hA5);
        prescale = 16'd9;
        hold(10);

        // 1-cycle low glitch centred on each high data bit of 8'hF0
        snap();
        rx = 1'b0;
        hold(5*P);            // start bit + four low data bits
        for (int i = 0; i < 4; i++) begin
            rx = 1'b1;
            hold(H);
            rx = 1'b0;
            hold(1);
            rx = 1'b1;
            hold(P - H - 1);
        end
        rx = 1'b1;
        hold(P + 10);
        chk("maj_rise", rise_cnt - s_rise, 1);
        chk("maj_data", rise_data, (LAG == 1) ? 8'hF0 : 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_byte_rx.md
# uart_byte_rx

Serial-to-parallel UART receiver: the receive side of the host-to-FPGA link, and the counterpart of the `uart_tx` serializer already used in the codebase. It recovers 8N1 frames from an asynchronous `rx_i` line and presents each byte on an AXI-Stream master interface. It uses the same `prescale` convention as `uart_tx`, so both directions share one baud setting. It also serves as the bench-side monitor that decodes `uart_alu` transmit output.

## Interface
- `DATA_WIDTH`, default 8: number of data bits per frame, LSB first.
- `clk_i` input 1: system clock; all logic is on the rising edge.
- `rst_i` input 1: synchronous, active-high reset.
- `rx_i` input 1: asynchronous serial line; idles high.
- `prescale_i` input 16: bit period equals `prescale_i*8` clock cycles. Sampled at start detection; 0 is treated as 1.
- `m_axis_tdata_o` output DATA_WIDTH: received byte.
- `m_axis_tvalid_o` output 1: byte available.
- `m_axis_tready_i` input 1: consumer accepts the byte.
- `busy_o` output 1: a frame is in progress (any state other than IDLE).
- `overrun_error_o` output 1: one-cycle pulse when a new byte lands while the previous byte is unaccepted.
- `frame_error_o` output 1: one-cycle pulse when the stop bit samples low.

## Operation
- `rx_i` passes through a 2-flop synchronizer that resets to 1. All logic uses the synchronized `rxs`.
- Let P = `prescale_i*8`, latched as the bit period; H = P/2.
- **IDLE:** on `rxs`=0, latch P, clear the counter, go to START.
- **START:** after H cycles, sample `rxs`.
  - If 1, it was a false start: return to IDLE with no flags.
  - Otherwise go to DATA.
- **DATA:** every P cycles, sample one bit into a shift register, LSB first. After DATA_WIDTH bits, go to STOP.
- **STOP:** after P cycles, sample `rxs`.
  - If 1: load `m_axis_tdata_o` with the shift register and set `m_axis_tvalid_o`. If `tvalid` was already high and not accepted that same cycle, pulse `overrun_error_o`; the new byte overwrites the old one. Go to IDLE.
  - If 0: pulse `frame_error_o`, discard the byte, go to WAIT_HIGH.
- **WAIT_HIGH:** remain until `rxs`=1, then go to IDLE. This prevents a break condition from being read as repeated starts.
- **Handshake:** `tvalid` stays high until a cycle with `tvalid && tready`, then clears on the next edge. If that cycle coincides with a new byte load, the load wins and `tvalid` stays high with no overrun flagged.
- Changing `prescale_i` mid-frame has no effect until the next start.

## Timing
- Reset values:
  - `m_axis_tvalid_o`=0, `m_axis_tdata_o`=0.
  - `busy_o`=0, `overrun_error_o`=0, `frame_error_o`=0.
  - State is IDLE; synchronizer flops are 1.
- Reset mid-frame aborts the frame immediately: no `tvalid` and no error flags.
- Take the falling edge at `rx_i` as cycle 0. `busy_o` rises at cycle 3. The start bit is sampled at cycle 2+H.
- Data bit i (0-based) is sampled at 2+H+(i+1)P; the stop bit is sampled at 2+H+(DATA_WIDTH+1)P.
- `m_axis_tvalid_o` rises on the cycle after the stop sample. `busy_o` falls on the same cycle.
- Error pulses are exactly one cycle long, on the cycle after the stop sample.
- Back-to-back frames: the next start edge can be detected from the first cycle after the return to IDLE.

## Configuration
- `UART_RX_MAJORITY_EN`:
  - Defined: each start, data and stop sample is the 2-of-3 majority of `rxs` at the nominal sample cycle −1, 0 and +1. Every sample decision, and therefore `tvalid`, moves one cycle later.
  - Undefined: single sample at the nominal cycle.
- Ports and parameters are identical in both builds.

## Test plan
- **Basic byte:** `prescale_i`=9 (P=72), `tready`=1, send 8'h55 via `uart_tx` → `tdata`=8'h55 with `tvalid` high for exactly 1 cycle, rising 2+36+648+1 cycles (±2) after the start edge; no error flags.
- **Backpressure and overrun:** `tready`=0, send 8'hA3 then 8'h3C back-to-back → first `tvalid` holds 8'hA3; at the second stop, `overrun_error_o` pulses once and `tdata`=8'h3C; raise `tready` → `tvalid` clears the next cycle.
- **False start:** low glitch of 20 cycles with P=72 → returns to IDLE; no `tvalid`, no flags; `busy_o` high for at most 37 cycles.
- **Framing error:** frame 8'hFF with the stop bit forced low, line held low for 3P, then a valid 8'h12 → `frame_error_o` pulses once; no `tvalid` for the bad frame; 8'h12 is received correctly.
- **Reset mid-frame:** assert `rst_i` for 1 cycle during data bit 4 of 8'hC7 → all outputs return to 0 the next cycle; a following 8'h81 is received correctly.
- **Majority filter (`UART_RX_MAJORITY_EN` defined):** 1-cycle low glitch at the center of each high data bit of 8'hF0 → `tdata`=8'hF0. With the macro undefined, the same stimulus yields a different byte.
